uart_loopback_checker: RTL

- Self-test initiator for the UART path, sitting on the far side of an echo loop (board-level loopback or device echo firmware).
- Generates a pseudo-random byte stream and hands each byte to a uart_tx instance via its write_i/data_i strobe interface.
- Waits for each byte to return through a uart_rx instance (data_o/valid_o), then compares it against the byte that was sent.
- Reports done, pass, error count and timeout for LEDs or a status register.

---
 rtl/uart_loopback_checker_pkg.sv | 22 ++
 rtl/uart_loopback_checker_lfsr8.sv | 36 +++
 rtl/uart_loopback_checker.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_loopback_checker_pkg.sv
// Shared definitions for the UART loopback checker: FSM states, LFSR taps and defaults.
// The testbench imports this package as well.
package uart_loopback_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Feedback taps on bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS       = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED    = 8'h01;
    localparam int         DEFAULT_TIMEOUT = 4096;
    localparam int         DEFAULT_COUNT   = 256;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/uart_loopback_checker_lfsr8.sv
// 8-bit Fibonacci LFSR producing the test byte stream; loads the seed on reset or load,
// steps only when advance is asserted.
module uart_loopback_checker_lfsr8
    import uart_loopback_checker_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       advance,
    output logic [7:0] value
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = seed;
        end else if (advance) begin
            value_d = lfsr_next(value_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= seed;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/uart_loopback_checker.sv
// UART echo-loop self-test: sends COUNT pseudo-random bytes one at a time, checks each echo,
// and reports done / pass / error count / timeout.
module uart_loopback_checker
    import uart_loopback_checker_pkg::*;
#(
    parameter int         COUNT          = DEFAULT_COUNT,
    parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter logic [7:0] SEED           = DEFAULT_SEED
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_i,
    output logic        tx_write_o,
    output logic [7:0]  tx_data_o,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] error_count_o,
    output logic        timeout_o
);

    localparam int            TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]   COUNT_W    = 16'(COUNT);

    state_t        state_q;
    logic          tx_write_q;
    logic [7:0]    tx_data_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic [15:0]   err_q;
    logic          timeout_q;
    logic [15:0]   sent_q;
    logic [TW-1:0] timer_q;

    logic       start_go;
    logic       lfsr_adv;
    logic [7:0] lfsr_val;
    logic [15:0] err_rx;
    logic       last_byte;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign start_go  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign lfsr_adv  = (state_q == ST_WAIT) && rx_valid_i;
    assign err_rx    = (rx_data_i != lfsr_val) ? sat_inc(err_q) : err_q;
    assign last_byte = ((sent_q + 16'd1) == COUNT_W);

    uart_loopback_checker_lfsr8 u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .load    (start_go),
        .seed    (SEED),
        .advance (lfsr_adv),
        .value   (lfsr_val)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tx_write_q <= 1'b0;
            tx_data_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 16'd0;
            timeout_q  <= 1'b0;
            sent_q     <= 16'd0;
            timer_q    <= '0;
        end else begin
            tx_write_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        err_q     <= 16'd0;
                        timeout_q <= 1'b0;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        sent_q    <= 16'd0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_write_q <= 1'b1;
                    tx_data_q  <= lfsr_val;
                    timer_q    <= TIMER_LOAD;
                    state_q    <= ST_WAIT;
                    // A byte arriving before anything is in flight is a stray.
                    if (rx_valid_i) begin
                        err_q <= sat_inc(err_q);
                    end
                end
                ST_WAIT: begin
                    if (rx_valid_i) begin
                        err_q  <= err_rx;
                        sent_q <= sent_q + 16'd1;
                        if (last_byte) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_rx == 16'd0) && !timeout_q;
                        end else begin
                            state_q <= ST_SEND;
                        end
                    end else if (timer_q == '0) begin
                        timeout_q <= 1'b1;
                        err_q     <= sat_inc(err_q);
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
            endcase
        end
    end

    assign tx_write_o    = tx_write_q;
    assign tx_data_o     = tx_data_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign error_count_o = err_q;
    assign timeout_o     = timeout_q;

endmodule
